event_stack_rpl: RTL and testbench

EVENT_STACK_RPL -- requirements
Module: event_stack_rpl

---
 rtl/event_stack_rpl.sv | 156 +++++++++++++++
 tb/tb_event_stack_rpl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_stack_rpl.sv
// Event stack: circular register store of DEPTH entries with oldest-first or newest-first replay.
// Define EVENT_STACK_DROP_OLDEST_EN to overwrite the oldest entry on a push while full (default: reject).
module event_stack_rpl #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 24,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  clear,
    input  logic                  stream_out,
    input  logic                  order,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  done,
    output logic                  busy,
    output logic [CW-1:0]         active_entries,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IW-1:0]         wp_q, wp_d;
    logic [IW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         left_q, left_d;
    logic                  order_q, order_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;
    logic                  mem_we;
    logic [CW-1:0]         wp_ext;
    logic [CW-1:0]         oldest_ext;
    logic [IW-1:0]         oldest_idx;
    logic [IW-1:0]         newest_idx;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [IW-1:0] idx_dec(input logic [IW-1:0] i);
        return (i == '0) ? LAST_IDX : i - 1'b1;
    endfunction

    // Oldest entry sits cnt slots behind the write pointer, wrapped modulo DEPTH.
    always_comb begin
        wp_ext     = CW'(wp_q);
        oldest_ext = (wp_ext >= cnt_q) ? (wp_ext - cnt_q) : (DEPTH_CNT - (cnt_q - wp_ext));
        oldest_idx = IW'(oldest_ext);
        newest_idx = idx_dec(wp_q);
    end

    // NOTE: every signal assigned in this block gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        wp_d       = wp_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        order_d    = order_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (stream_out) begin
                    if (cnt_q != '0) begin
                        state_d = STREAM;
                        order_d = order;
                        left_d  = cnt_q;
                        rd_d    = order ? newest_idx : oldest_idx;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (wr_en) begin
                    if (cnt_q != DEPTH_CNT) begin
                        mem_we = 1'b1;
                        wp_d   = idx_inc(wp_q);
                        cnt_d  = cnt_q + 1'b1;
                    end else begin
                        overflow_d = 1'b1;
`ifdef EVENT_STACK_DROP_OLDEST_EN
                        mem_we = 1'b1;
                        wp_d   = idx_inc(wp_q);
`endif
                    end
                end else if (clear) begin
                    cnt_d      = '0;
                    wp_d       = '0;
                    overflow_d = 1'b0;
                end
            end
            STREAM: begin
                if (dout_ready) begin
                    if (left_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        left_d = left_q - 1'b1;
                        rd_d   = order_q ? idx_dec(rd_q) : idx_inc(rd_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wp_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            left_q     <= '0;
            order_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            left_q     <= left_d;
            order_q    <= order_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // NOTE: storage is deliberately not reset; cnt/wp define which slots hold valid data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wp_q] <= din;
        end
    end

    assign dout_valid     = (state_q == STREAM);
    assign busy           = (state_q == STREAM);
    assign dout           = dout_valid ? mem_q[rd_q] : '0;
    assign done           = done_q;
    assign active_entries = cnt_q;
    assign empty          = (cnt_q == '0);
    assign full           = (cnt_q == DEPTH_CNT);
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_event_stack_rpl.sv
// Scoreboard bench for event_stack_rpl: expected replay data is queued at stimulus time and popped per handshake.
module tb_event_stack_rpl;
    localparam int DW    = 8;
    localparam int DEPTH = 24;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr_en = 1'b0;
    logic          clear = 1'b0;
    logic          stream_out = 1'b0;
    logic          order = 1'b0;
    logic          dout_ready = 1'b1;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          done;
    logic          busy;
    logic [CW-1:0] active_entries;
    logic          empty;
    logic          full;
    logic          overflow;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] sb[$];
    int            hs_cyc[$];
    int            done_cyc[$];
    logic          stalled = 1'b0;
    logic [DW-1:0] held = '0;

    event_stack_rpl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .clear(clear),
        .stream_out(stream_out), .order(order), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .done(done), .busy(busy),
        .active_entries(active_entries), .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Sample outputs on the falling edge, then let the next rising edge apply the current inputs.
    task automatic tick();
        logic [DW-1:0] exp_v;
        @(negedge clk);
        cyc++;
        if (dout_valid && dout_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: dout=%0d with no entry expected", dout);
            end else begin
                exp_v = sb.pop_front();
                if (dout !== exp_v) begin
                    bad++;
                    $display("FAIL replay_data: got %0d want %0d (cycle %0d)", dout, exp_v, cyc);
                end
            end
            hs_cyc.push_back(cyc);
        end
        if (stalled) begin
            total++;
            if (dout_valid !== 1'b1 || dout !== held) begin
                bad++;
                $display("FAIL stall_hold: valid=%0b dout=%0d want valid=1 dout=%0d", dout_valid, dout, held);
            end
        end
        if (!dout_valid) begin
            total++;
            if (dout !== '0) begin
                bad++;
                $display("FAIL dout_idle_zero: got %0d want 0", dout);
            end
        end
        if (done) begin
            done_cyc.push_back(cyc);
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL done_busy: busy=%0b want 0 during done", busy);
            end
        end
        stalled = dout_valid && !dout_ready && !rst;
        held    = dout;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        wr_en = 1'b1;
        din   = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Starts a replay and runs until done; junk drives wr_en/clear/stream_out during the first STREAM cycles.
    task automatic run_replay(input logic ord, input bit toggle, input bit junk,
                              output int nhs, output int ndone, output int s_cyc,
                              output int first_hs, output int last_hs, output int done_at);
        int h0, d0, k;
        h0 = hs_cyc.size();
        d0 = done_cyc.size();
        stream_out = 1'b1;
        order      = ord;
        dout_ready = 1'b1;
        tick();
        s_cyc      = cyc;
        stream_out = 1'b0;
        order      = 1'b0;
        k = 0;
        while (done_cyc.size() == d0 && k < 200) begin
            dout_ready = !toggle || (k % 2 == 0);
            if (junk && k < 3) begin
                wr_en = 1'b1; din = 8'd9; clear = 1'b1; stream_out = 1'b1;
            end else begin
                wr_en = 1'b0; clear = 1'b0; stream_out = 1'b0;
            end
            tick();
            k++;
        end
        wr_en = 1'b0; clear = 1'b0; stream_out = 1'b0; dout_ready = 1'b1;
        tick();
        tick();
        total++;
        if (k >= 200) begin
            bad++;
            $display("FAIL replay_timeout: no done within %0d cycles", k);
        end
        nhs      = hs_cyc.size() - h0;
        ndone    = done_cyc.size() - d0;
        first_hs = (nhs > 0) ? hs_cyc[h0] : -1;
        last_hs  = (nhs > 0) ? hs_cyc[hs_cyc.size() - 1] : -1;
        done_at  = (ndone > 0) ? done_cyc[d0] : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({busy, dout_valid, done, overflow, full, empty} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_flags: busy/valid/done/ovf/full/empty=%b want 000001",
                     {busy, dout_valid, done, overflow, full, empty});
        end
        total++;
        if (active_entries !== '0 || dout !== '0) begin
            bad++;
            $display("FAIL reset_count: count=%0d dout=%0d want 0 0", active_entries, dout);
        end
    endtask

    task automatic test_oldest_first();
        int nhs, ndone, s, f, l, d;
        push(8'd3); push(8'd5); push(8'd7);
        sb.push_back(8'd3); sb.push_back(8'd5); sb.push_back(8'd7);
        run_replay(1'b0, 1'b0, 1'b0, nhs, ndone, s, f, l, d);
        total++;
        if (nhs !== 3 || ndone !== 1) begin
            bad++;
            $display("FAIL oldest_counts: handshakes=%0d dones=%0d want 3 1", nhs, ndone);
        end
        total++;
        if (f !== s + 1 || l !== s + 3 || d !== s + 4) begin
            bad++;
            $display("FAIL oldest_timing: first=%0d last=%0d done=%0d want %0d %0d %0d",
                     f - s, l - s, d - s, 1, 3, 4);
        end
        total++;
        if (active_entries !== CW'(3) || sb.size() !== 0) begin
            bad++;
            $display("FAIL oldest_after: count=%0d leftover=%0d want 3 0", active_entries, sb.size());
        end
    endtask

    task automatic test_newest_stall();
        int nhs, ndone, s, f, l, d;
        sb.push_back(8'd7); sb.push_back(8'd5); sb.push_back(8'd3);
        run_replay(1'b1, 1'b1, 1'b0, nhs, ndone, s, f, l, d);
        total++;
        if (nhs !== 3 || ndone !== 1) begin
            bad++;
            $display("FAIL newest_counts: handshakes=%0d dones=%0d want 3 1", nhs, ndone);
        end
        total++;
        if (l !== s + 5 || d !== s + 6) begin
            bad++;
            $display("FAIL newest_timing: last=%0d done=%0d want 5 6", l - s, d - s);
        end
        total++;
        if (active_entries !== CW'(3) || sb.size() !== 0) begin
            bad++;
            $display("FAIL newest_after: count=%0d leftover=%0d want 3 0", active_entries, sb.size());
        end
    endtask

    task automatic test_empty_stream();
        int nhs, ndone, s, f, l, d;
        do_clear();
        total++;
        if (empty !== 1'b1 || active_entries !== '0) begin
            bad++;
            $display("FAIL empty_clear: empty=%0b count=%0d want 1 0", empty, active_entries);
        end
        run_replay(1'b0, 1'b0, 1'b0, nhs, ndone, s, f, l, d);
        total++;
        if (nhs !== 0 || ndone !== 1 || d !== s + 1) begin
            bad++;
            $display("FAIL empty_stream: handshakes=%0d dones=%0d done_at=%0d want 0 1 1", nhs, ndone, d - s);
        end
    endtask

    task automatic test_overflow();
        int nhs, ndone, s, f, l, d, base;
        for (int i = 0; i < DEPTH; i++) push(DW'(i));
        total++;
        if (full !== 1'b1 || overflow !== 1'b0 || active_entries !== CW'(DEPTH)) begin
            bad++;
            $display("FAIL fill_exact: full=%0b ovf=%0b count=%0d want 1 0 %0d", full, overflow, active_entries, DEPTH);
        end
        push(DW'(DEPTH));
        total++;
        if (full !== 1'b1 || overflow !== 1'b1 || active_entries !== CW'(DEPTH)) begin
            bad++;
            $display("FAIL overflow_push: full=%0b ovf=%0b count=%0d want 1 1 %0d", full, overflow, active_entries, DEPTH);
        end
`ifdef EVENT_STACK_DROP_OLDEST_EN
        base = 1;
`else
        base = 0;
`endif
        for (int i = 0; i < DEPTH; i++) sb.push_back(DW'(base + i));
        run_replay(1'b0, 1'b0, 1'b0, nhs, ndone, s, f, l, d);
        total++;
        if (nhs !== DEPTH || ndone !== 1 || l !== s + DEPTH) begin
            bad++;
            $display("FAIL overflow_replay: handshakes=%0d dones=%0d span=%0d want %0d 1 %0d", nhs, ndone, l - s, DEPTH, DEPTH);
        end
    endtask

    task automatic test_ignore_in_stream();
        int nhs, ndone, s, f, l, d, base;
`ifdef EVENT_STACK_DROP_OLDEST_EN
        base = 1;
`else
        base = 0;
`endif
        for (int i = DEPTH - 1; i >= 0; i--) sb.push_back(DW'(base + i));
        run_replay(1'b1, 1'b0, 1'b1, nhs, ndone, s, f, l, d);
        total++;
        if (nhs !== DEPTH || ndone !== 1) begin
            bad++;
            $display("FAIL ignore_counts: handshakes=%0d dones=%0d want %0d 1", nhs, ndone, DEPTH);
        end
        total++;
        if (active_entries !== CW'(DEPTH) || overflow !== 1'b1 || sb.size() !== 0) begin
            bad++;
            $display("FAIL ignore_state: count=%0d ovf=%0b leftover=%0d want %0d 1 0", active_entries, overflow, sb.size(), DEPTH);
        end
        do_clear();
        total++;
        if (empty !== 1'b1 || overflow !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL clear_after: empty=%0b ovf=%0b full=%0b want 1 0 0", empty, overflow, full);
        end
    endtask

    task automatic test_rst_mid_replay();
        int d0, h0;
        push(8'd1); push(8'd2); push(8'd3);
        d0 = done_cyc.size();
        h0 = hs_cyc.size();
        dout_ready = 1'b0;
        stream_out = 1'b1;
        tick();
        stream_out = 1'b0;
        tick();
        total++;
        if (dout_valid !== 1'b1 || dout !== 8'd1) begin
            bad++;
            $display("FAIL rst_prestall: valid=%0b dout=%0d want 1 1", dout_valid, dout);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dout_ready = 1'b1;
        total++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || active_entries !== '0) begin
            bad++;
            $display("FAIL rst_abort: valid=%0b busy=%0b count=%0d want 0 0 0", dout_valid, busy, active_entries);
        end
        repeat (4) tick();
        total++;
        if (done_cyc.size() !== d0 || hs_cyc.size() !== h0) begin
            bad++;
            $display("FAIL rst_no_done: dones=%0d handshakes=%0d want 0 0", done_cyc.size() - d0, hs_cyc.size() - h0);
        end
    endtask

    initial begin
        test_reset();
        test_oldest_first();
        test_newest_stall();
        test_empty_stream();
        test_overflow();
        test_ignore_in_stream();
        test_rst_mid_replay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
